// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: IF-stage fetch-PC generator with an in-order queue of
// aligned multi-instruction fetch groups feeding ICache/ID.
//
// Handshake: out_valid is high whenever the queue holds at least one group.
// A group is consumed on a cycle where out_valid && out_ready && !stall and
// no redirect is taking place. While it is not consumed, the head group and
// all out_* fields stay stable. When the queue is empty, out_pc, out_mask
// and out_branch keep their last value.
module fetch_pc_queue #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h1c000000,
    parameter int                    FETCH_WIDTH  = 2,
    parameter int                    QUEUE_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    input  logic                   branch,
    input  logic [ADDR_WIDTH-1:0]  predict_pc,
    input  logic                   stall,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [FETCH_WIDTH-1:0] out_mask,
    output logic                   out_branch
);

    localparam int GB    = FETCH_WIDTH * 4;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   br_pend_q, br_pend_d;
    logic [PTR_W-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic [FETCH_WIDTH-1:0] out_mask_q, out_mask_d;
    logic                   out_br_q, out_br_d;

    logic [ADDR_WIDTH-1:0]  q_pc   [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0] q_mask [QUEUE_DEPTH];
    logic                   q_br   [QUEUE_DEPTH];

    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  slot_off;
    logic [ADDR_WIDTH-1:0]  grp_base;
    logic [FETCH_WIDTH-1:0] cur_mask;
    logic                   full;
    logic                   push;
    logic                   pop;

    // Redirect selection (flush beats branch) and fetch-group geometry of pc_q
    always_comb begin
        redirect    = flush | branch;
        redirect_pc = (flush ? flush_pc : predict_pc) & ~ADDR_WIDTH'(3);
        slot_off    = (pc_q >> 2) & ADDR_WIDTH'(FETCH_WIDTH - 1);
        grp_base    = pc_q & ~ADDR_WIDTH'(GB - 1);
        cur_mask    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            cur_mask[i] = (ADDR_WIDTH'(i) >= slot_off);
        end
        full      = (cnt_q == CNT_W'(QUEUE_DEPTH));
        out_valid = (cnt_q != '0);
        pop       = out_valid && out_ready && !stall && !redirect;
        push      = !redirect && (!full || pop);
    end

    // Next-state for PC, branch tag, queue pointers and head output registers
    always_comb begin
        pc_d       = pc_q;
        br_pend_d  = br_pend_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        out_pc_d   = out_pc_q;
        out_mask_d = out_mask_q;
        out_br_d   = out_br_q;
        if (redirect) begin
            pc_d      = redirect_pc;
            br_pend_d = !flush;
            rd_d      = '0;
            wr_d      = '0;
            cnt_d     = '0;
        end else begin
            if (push) begin
                pc_d      = grp_base + ADDR_WIDTH'(GB);
                br_pend_d = 1'b0;
                wr_d      = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            // Head after this edge: an already-queued entry if one survives
            // the pop, otherwise the group being pushed now.
            if ((cnt_q > CNT_W'(1)) || (cnt_q == CNT_W'(1) && !pop)) begin
                out_pc_d   = q_pc[rd_d];
                out_mask_d = q_mask[rd_d];
                out_br_d   = q_br[rd_d];
            end else if (push) begin
                out_pc_d   = pc_q;
                out_mask_d = cur_mask;
                out_br_d   = br_pend_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            br_pend_q  <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            out_pc_q   <= '0;
            out_mask_q <= '0;
            out_br_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            br_pend_q  <= br_pend_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            out_pc_q   <= out_pc_d;
            out_mask_q <= out_mask_d;
            out_br_q   <= out_br_d;
        end
    end

    // Queue storage write; contents are only meaningful between rd and wr
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[wr_q]   <= pc_q;
            q_mask[wr_q] <= cur_mask;
            q_br[wr_q]   <= br_pend_q;
        end
    end

    assign out_pc     = out_pc_q;
    assign out_mask   = out_mask_q;
    assign out_branch = out_br_q;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue (ADDR_WIDTH=32, FETCH_WIDTH=2, QUEUE_DEPTH=4).
module tb_fetch_pc_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch;
    logic [31:0] predict_pc;
    logic        stall;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [1:0]  out_mask;
    logic        out_branch;

    int tests = 0;
    int fails = 0;

    fetch_pc_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .branch     (branch),
        .predict_pc (predict_pc),
        .stall      (stall),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_mask   (out_mask),
        .out_branch (out_branch)
    );

    // clock
    always #5 clk = ~clk;

    // advance one edge; outputs are then sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // check the full head group
    task automatic chk_grp(input string tag, input logic [31:0] pc, input logic [1:0] mask,
                           input logic br);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".mask"}, {30'd0, out_mask}, {30'd0, mask});
        chk({tag, ".branch"}, {31'd0, out_branch}, {31'd0, br});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0; branch = 1'b0; predict_pc = '0;
        stall = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.mask", {30'd0, out_mask}, 32'd0);
        chk("rst.branch", {31'd0, out_branch}, 32'd0);

        // 1: reset release, sequential groups every cycle
        rst = 1'b0; out_ready = 1'b1;
        step(); chk_grp("seq0", 32'h1c000000, 2'b11, 1'b0);
        step(); chk_grp("seq1", 32'h1c000008, 2'b11, 1'b0);
        step(); chk_grp("seq2", 32'h1c000010, 2'b11, 1'b0);

        // 2: branch to odd slot
        branch = 1'b1; predict_pc = 32'h1c000104;
        step(); chk("br.gap", {31'd0, out_valid}, 32'd0);
        branch = 1'b0;
        step(); chk_grp("br.tgt", 32'h1c000104, 2'b10, 1'b1);
        step(); chk_grp("br.next", 32'h1c000108, 2'b11, 1'b0);

        // 3: flush and branch together, flush wins
        flush = 1'b1; flush_pc = 32'h1c000200; branch = 1'b1; predict_pc = 32'h1c000300;
        step(); chk("fl.gap", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; branch = 1'b0;
        step(); chk_grp("fl.tgt", 32'h1c000200, 2'b11, 1'b0);
        step(); chk_grp("fl.next", 32'h1c000208, 2'b11, 1'b0);

        // 4: backpressure fills queue, head stable, then ordered drain
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(); chk_grp("bp.hold", 32'h1c000208, 2'b11, 1'b0);
        end
        out_ready = 1'b1;
        step(); chk_grp("bp.d0", 32'h1c000210, 2'b11, 1'b0);
        step(); chk_grp("bp.d1", 32'h1c000218, 2'b11, 1'b0);
        step(); chk_grp("bp.d2", 32'h1c000220, 2'b11, 1'b0);
        step(); chk_grp("bp.d3", 32'h1c000228, 2'b11, 1'b0);
        step(); chk_grp("bp.d4", 32'h1c000230, 2'b11, 1'b0);

        // 5: address wrap
        branch = 1'b1; predict_pc = 32'hfffffff8;
        step(); chk("wr.gap", {31'd0, out_valid}, 32'd0);
        branch = 1'b0;
        step(); chk_grp("wr.top", 32'hfffffff8, 2'b11, 1'b1);
        step(); chk_grp("wr.zero", 32'h00000000, 2'b11, 1'b0);
        step(); chk_grp("wr.eight", 32'h00000008, 2'b11, 1'b0);

        // 6: stall while filling/full, release, then reset mid-drain
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); chk_grp("st.hold", 32'h00000008, 2'b11, 1'b0);
        end
        stall = 1'b0;
        step(); chk_grp("st.d0", 32'h00000010, 2'b11, 1'b0);
        step(); chk_grp("st.d1", 32'h00000018, 2'b11, 1'b0);
        rst = 1'b1;
        step();
        chk("mr.valid", {31'd0, out_valid}, 32'd0);
        chk("mr.pc", out_pc, 32'd0);
        rst = 1'b0;
        step(); chk_grp("mr.restart", 32'h1c000000, 2'b11, 1'b0);
        step(); chk_grp("mr.next", 32'h1c000008, 2'b11, 1'b0);

        // misaligned branch target: low bits dropped
        branch = 1'b1; predict_pc = 32'h1c00000f;
        step(); chk("mis.gap", {31'd0, out_valid}, 32'd0);
        branch = 1'b0;
        step(); chk_grp("mis.tgt", 32'h1c00000c, 2'b10, 1'b1);
        step(); chk_grp("mis.next", 32'h1c000010, 2'b11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
